// File: rtl/gpio_port_irq.sv
// N-pin GPIO port: per-pin function mux, pull control, 2-FF input sync, edge flags and interrupt vector.
// Optional glitch filter on the synchronised input is enabled by defining GPIO_GLITCH_FILTER_EN.
module gpio_port_irq #(
  parameter int WIDTH    = 8,
  parameter int FILT_CYC = 4
) (
  input  logic                 MCLK,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     pad_i,
  output logic [WIDTH-1:0]     pad_o,
  output logic [WIDTH-1:0]     pad_oe,
  output logic [WIDTH-1:0]     pad_pull_en,
  output logic [WIDTH-1:0]     pad_pull_up,
  input  logic [WIDTH-1:0]     px_out,
  input  logic [WIDTH-1:0]     px_dir,
  input  logic [WIDTH-1:0]     px_ren,
  input  logic [WIDTH-1:0]     px_ies,
  input  logic [WIDTH-1:0]     px_ie,
  input  logic [2*WIDTH-1:0]   px_sel,
  input  logic [3*WIDTH-1:0]   alt_out,
  input  logic [3*WIDTH-1:0]   alt_dir,
  output logic [3*WIDTH-1:0]   alt_in,
  output logic [WIDTH-1:0]     px_in,
  input  logic                 ifg_wr,
  input  logic [WIDTH-1:0]     ifg_wdata,
  input  logic                 iv_rd,
  output logic [WIDTH-1:0]     px_ifg,
  output logic [15:0]          px_iv,
  output logic                 irq
);

  if (WIDTH < 1 || WIDTH > 16 || FILT_CYC < 1) begin : g_bad_params
    $error("gpio_port_irq: WIDTH must be 1..16 and FILT_CYC >= 1");
  end

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic             arm;
  logic [1:0]       arm_cnt;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] lowest;
  logic [WIDTH-1:0] ifg_base;
  logic [WIDTH-1:0] ifg_next;
  logic [15:0]      iv_next;

  // Edge detection stays disarmed until prev holds a real pad sample, so a pin
  // that is already high when reset releases cannot look like a rising edge.
`ifdef GPIO_GLITCH_FILTER_EN
  localparam logic [1:0] ARM_LAST = 2'd3;
  localparam int         CW       = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;

  logic [CW-1:0] filt_cnt [WIDTH];

  always_ff @(posedge MCLK) begin
    if (reset) begin
      px_in <= '0;
      for (int i = 0; i < WIDTH; i++) filt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!arm) begin
          px_in[i]    <= sync2[i];
          filt_cnt[i] <= '0;
        end else if (sync2[i] == px_in[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == CW'(FILT_CYC - 1)) begin
          px_in[i]    <= sync2[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  localparam logic [1:0] ARM_LAST = 2'd2;

  assign px_in = sync2;
`endif

  always_comb begin
    logic [1:0] sel;
    logic       oe;
    pad_o       = '0;
    pad_oe      = '0;
    pad_pull_en = '0;
    pad_pull_up = '0;
    alt_in      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sel = px_sel[2*i +: 2];
      if (sel == 2'd0) begin
        oe       = px_dir[i];
        pad_o[i] = px_out[i];
      end else begin
        oe       = alt_dir[(int'(sel) - 1) * WIDTH + i];
        pad_o[i] = alt_out[(int'(sel) - 1) * WIDTH + i];
      end
      pad_oe[i]      = oe;
      pad_pull_en[i] = ~oe & px_ren[i];
      pad_pull_up[i] = px_out[i];
      for (int k = 0; k < 3; k++) begin
        alt_in[k * WIDTH + i] = (int'(sel) == k + 1) & px_in[i];
      end
    end
  end

  // Write beats read-to-clear; a same-cycle edge always survives either.
  always_comb begin
    edge_det = arm ? ((px_ies & prev & ~px_in) | (~px_ies & ~prev & px_in)) : '0;
    lowest   = px_ifg & (~px_ifg + WIDTH'(1));
    if (ifg_wr)     ifg_base = ifg_wdata;
    else if (iv_rd) ifg_base = px_ifg & ~lowest;
    else            ifg_base = px_ifg;
    ifg_next = ifg_base | edge_det;
    iv_next  = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (ifg_next[i]) iv_next = 16'(2 * (i + 1));
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      arm     <= 1'b0;
      arm_cnt <= '0;
      px_ifg  <= '0;
      px_iv   <= '0;
      irq     <= 1'b0;
    end else begin
      sync1  <= pad_i;
      sync2  <= sync1;
      prev   <= px_in;
      px_ifg <= ifg_next;
      px_iv  <= iv_next;
      irq    <= |(px_ifg & px_ie);
      if (!arm) begin
        arm_cnt <= arm_cnt + 1'b1;
        arm     <= (arm_cnt == ARM_LAST);
      end
    end
  end

endmodule

// File: tb/tb_gpio_port_irq.sv
// Scoreboard bench for gpio_port_irq: stimulus queues expected values tagged with a due cycle,
// a negedge monitor pops and compares them. Filter expectations follow GPIO_GLITCH_FILTER_EN.
module tb_gpio_port_irq;

  localparam int WIDTH    = 8;
  localparam int FILT_CYC = 4;
`ifdef GPIO_GLITCH_FILTER_EN
  localparam int  LAT      = 2 + FILT_CYC;
  localparam logic [31:0] SHORT_PULSE_IFG = 32'h00;
`else
  localparam int  LAT      = 2;
  localparam logic [31:0] SHORT_PULSE_IFG = 32'h08;
`endif

  logic                 MCLK;
  logic                 reset;
  logic [WIDTH-1:0]     pad_i;
  logic [WIDTH-1:0]     pad_o;
  logic [WIDTH-1:0]     pad_oe;
  logic [WIDTH-1:0]     pad_pull_en;
  logic [WIDTH-1:0]     pad_pull_up;
  logic [WIDTH-1:0]     px_out;
  logic [WIDTH-1:0]     px_dir;
  logic [WIDTH-1:0]     px_ren;
  logic [WIDTH-1:0]     px_ies;
  logic [WIDTH-1:0]     px_ie;
  logic [2*WIDTH-1:0]   px_sel;
  logic [3*WIDTH-1:0]   alt_out;
  logic [3*WIDTH-1:0]   alt_dir;
  logic [3*WIDTH-1:0]   alt_in;
  logic [WIDTH-1:0]     px_in;
  logic                 ifg_wr;
  logic [WIDTH-1:0]     ifg_wdata;
  logic                 iv_rd;
  logic [WIDTH-1:0]     px_ifg;
  logic [15:0]          px_iv;
  logic                 irq;

  gpio_port_irq #(.WIDTH(WIDTH), .FILT_CYC(FILT_CYC)) dut (
    .MCLK(MCLK), .reset(reset), .pad_i(pad_i), .pad_o(pad_o), .pad_oe(pad_oe),
    .pad_pull_en(pad_pull_en), .pad_pull_up(pad_pull_up),
    .px_out(px_out), .px_dir(px_dir), .px_ren(px_ren), .px_ies(px_ies), .px_ie(px_ie),
    .px_sel(px_sel), .alt_out(alt_out), .alt_dir(alt_dir), .alt_in(alt_in),
    .px_in(px_in), .ifg_wr(ifg_wr), .ifg_wdata(ifg_wdata), .iv_rd(iv_rd),
    .px_ifg(px_ifg), .px_iv(px_iv), .irq(irq)
  );

  typedef enum {K_IFG, K_IV, K_IRQ, K_OE, K_O, K_PEN, K_PUP, K_ALTIN, K_PXIN} kind_e;
  typedef struct {
    int          due;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  always @(posedge MCLK) cyc <= cyc + 1;

  function automatic string kindName(kind_e k);
    case (k)
      K_IFG:   return "px_ifg";
      K_IV:    return "px_iv";
      K_IRQ:   return "irq";
      K_OE:    return "pad_oe";
      K_O:     return "pad_o";
      K_PEN:   return "pad_pull_en";
      K_PUP:   return "pad_pull_up";
      K_ALTIN: return "alt_in";
      default: return "px_in";
    endcase
  endfunction

  function automatic logic [31:0] actualOf(kind_e k);
    case (k)
      K_IFG:   return 32'(px_ifg);
      K_IV:    return 32'(px_iv);
      K_IRQ:   return 32'(irq);
      K_OE:    return 32'(pad_oe);
      K_O:     return 32'(pad_o);
      K_PEN:   return 32'(pad_pull_en);
      K_PUP:   return 32'(pad_pull_up);
      K_ALTIN: return 32'(alt_in);
      default: return 32'(px_in);
    endcase
  endfunction

  // Monitor: compare every expectation whose due cycle has arrived.
  always @(negedge MCLK) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        act = actualOf(sb[i].kind);
        total++;
        if (act !== sb[i].exp) begin
          bad++;
          $display("[TB] FAIL %s cyc=%0d got=%h want=%h", kindName(sb[i].kind), cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic checkOutput(input kind_e k, input int delay, input logic [31:0] exp);
    exp_t e;
    e.due  = cyc + delay;
    e.kind = k;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] pad, input logic rd, input logic wr,
                               input logic [7:0] wdata);
    pad_i     = pad;
    iv_rd     = rd;
    ifg_wr    = wr;
    ifg_wdata = wdata;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset   = 1'b1;
    px_out  = '0; px_dir = '0; px_ren = '0; px_ies = '0; px_ie = '0;
    px_sel  = '0; alt_out = '0; alt_dir = '0;
    applyStimulus(8'hFF, 1'b0, 1'b0, 8'h00);
    $display("[TB] gpio_port_irq scoreboard bench, LAT=%0d", LAT);

    // Reset state, then release with all pads already high.
    waitCycles(3);
    checkOutput(K_IFG, 0, 32'h00);
    checkOutput(K_IV, 0, 32'h00);
    checkOutput(K_IRQ, 0, 32'h0);
    checkOutput(K_PXIN, 0, 32'h00);
    reset = 1'b0;
    checkOutput(K_PXIN, 5, 32'hFF);
    checkOutput(K_IFG, 8, 32'h00);
    checkOutput(K_IV, 8, 32'h00);
    waitCycles(9);

    // Function mux.
    px_dir = 8'hFF; px_out = 8'hA5;
    checkOutput(K_OE, 0, 32'hFF);
    checkOutput(K_O, 0, 32'hA5);
    waitCycles(1);
    px_sel = 16'h0080; alt_out = 24'h000800; alt_dir = 24'h000800;
    checkOutput(K_O, 0, 32'hAD);
    checkOutput(K_OE, 0, 32'hFF);
    checkOutput(K_ALTIN, 0, 32'h000800);
    waitCycles(1);
    alt_dir = 24'h000000;
    checkOutput(K_OE, 0, 32'hF7);
    waitCycles(1);

    // Pull control.
    px_sel = '0; alt_out = '0; px_dir = 8'h00; px_out = 8'h04; px_ren = 8'h04;
    checkOutput(K_PEN, 0, 32'h04);
    checkOutput(K_PUP, 0, 32'h04);
    checkOutput(K_ALTIN, 0, 32'h000000);
    waitCycles(1);
    px_dir = 8'h04;
    checkOutput(K_PEN, 0, 32'h00);
    waitCycles(1);
    px_dir = '0; px_ren = '0; px_out = '0;

    // Falling edges with ies=0 raise nothing.
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    waitCycles(LAT + 2);
    checkOutput(K_IFG, 0, 32'h00);
    checkOutput(K_PXIN, 0, 32'h00);

    // Pad-to-flag-to-irq latency on pin0.
    px_ie = 8'h01;
    applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
    checkOutput(K_PXIN, LAT, 32'h01);
    checkOutput(K_IFG, LAT, 32'h00);
    checkOutput(K_IFG, LAT + 1, 32'h01);
    checkOutput(K_IV, LAT + 1, 32'h02);
    checkOutput(K_IRQ, LAT + 1, 32'h0);
    checkOutput(K_IRQ, LAT + 2, 32'h1);
    waitCycles(LAT + 3);
    applyStimulus(8'h01, 1'b1, 1'b0, 8'h00);
    checkOutput(K_IV, 0, 32'h02);
    checkOutput(K_IFG, 1, 32'h00);
    checkOutput(K_IV, 1, 32'h00);
    checkOutput(K_IRQ, 1, 32'h1);
    checkOutput(K_IRQ, 2, 32'h0);
    waitCycles(1);
    applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
    waitCycles(2);

    // Vector priority across two read-to-clears.
    px_ie = 8'h12;
    applyStimulus(8'h01, 1'b0, 1'b1, 8'h12);
    checkOutput(K_IFG, 1, 32'h12);
    checkOutput(K_IV, 1, 32'h04);
    checkOutput(K_IRQ, 2, 32'h1);
    waitCycles(1);
    applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
    waitCycles(2);
    applyStimulus(8'h01, 1'b1, 1'b0, 8'h00);
    checkOutput(K_IFG, 1, 32'h10);
    checkOutput(K_IV, 1, 32'h0A);
    waitCycles(1);
    checkOutput(K_IFG, 1, 32'h00);
    checkOutput(K_IV, 1, 32'h00);
    checkOutput(K_IRQ, 1, 32'h1);
    checkOutput(K_IRQ, 2, 32'h0);
    waitCycles(1);
    applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
    waitCycles(2);

    // ie changes reach irq one cycle later.
    applyStimulus(8'h01, 1'b0, 1'b1, 8'h12);
    waitCycles(1);
    applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
    waitCycles(1);
    px_ie = 8'h00;
    checkOutput(K_IRQ, 0, 32'h1);
    checkOutput(K_IRQ, 1, 32'h0);
    waitCycles(1);
    px_ie = 8'h12;
    checkOutput(K_IRQ, 1, 32'h1);
    waitCycles(1);
    applyStimulus(8'h01, 1'b0, 1'b1, 8'h00);
    waitCycles(1);
    applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
    px_ie = 8'h00;

    // Read-to-clear racing a fresh edge on pin1: flag must stay.
    applyStimulus(8'h03, 1'b0, 1'b1, 8'h02);
    checkOutput(K_IFG, 1, 32'h02);
    waitCycles(1);
    applyStimulus(8'h03, 1'b0, 1'b0, 8'h00);
    waitCycles(LAT - 1);
    applyStimulus(8'h03, 1'b1, 1'b0, 8'h00);
    checkOutput(K_IFG, 1, 32'h02);
    checkOutput(K_IV, 1, 32'h04);
    waitCycles(1);

    // Write beats a simultaneous read-to-clear.
    applyStimulus(8'h03, 1'b0, 1'b1, 8'h06);
    checkOutput(K_IFG, 1, 32'h06);
    waitCycles(1);
    applyStimulus(8'h03, 1'b1, 1'b1, 8'h05);
    checkOutput(K_IFG, 1, 32'h05);
    checkOutput(K_IV, 1, 32'h02);
    waitCycles(1);
    applyStimulus(8'h03, 1'b1, 1'b1, 8'h00);
    checkOutput(K_IFG, 1, 32'h00);
    checkOutput(K_IV, 1, 32'h00);
    waitCycles(1);
    applyStimulus(8'h03, 1'b0, 1'b0, 8'h00);

    // Switching ies alone is silent; the later falling edge flags.
    px_ies = 8'h02;
    waitCycles(3);
    checkOutput(K_IFG, 0, 32'h00);
    applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
    checkOutput(K_IFG, LAT + 1, 32'h02);
    checkOutput(K_IV, LAT + 1, 32'h04);
    waitCycles(LAT + 2);
    applyStimulus(8'h01, 1'b0, 1'b1, 8'h00);
    waitCycles(1);
    applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
    px_ies = 8'h00;

    // Highest pin vector.
    applyStimulus(8'h81, 1'b0, 1'b0, 8'h00);
    checkOutput(K_IFG, LAT + 1, 32'h80);
    checkOutput(K_IV, LAT + 1, 32'h10);
    waitCycles(LAT + 2);

    // Reset mid-operation with an edge still in the synchroniser.
    applyStimulus(8'h85, 1'b0, 1'b0, 8'h00);
    waitCycles(1);
    reset = 1'b1;
    checkOutput(K_IFG, 1, 32'h00);
    checkOutput(K_IV, 1, 32'h00);
    checkOutput(K_IRQ, 1, 32'h0);
    checkOutput(K_PXIN, 1, 32'h00);
    waitCycles(1);
    reset = 1'b0;
    waitCycles(LAT + 6);
    checkOutput(K_IFG, 0, 32'h00);
    checkOutput(K_PXIN, 0, 32'h85);

    // Short pulse on pin3: rejected only when the filter is built in.
    applyStimulus(8'h8D, 1'b0, 1'b0, 8'h00);
    checkOutput(K_IFG, 12, SHORT_PULSE_IFG);
    waitCycles(3);
    applyStimulus(8'h85, 1'b0, 1'b0, 8'h00);
    waitCycles(10);
    applyStimulus(8'h85, 1'b0, 1'b1, 8'h00);
    waitCycles(1);
    applyStimulus(8'h85, 1'b0, 1'b0, 8'h00);

    // Longer pulse flags in either build.
    applyStimulus(8'h8D, 1'b0, 1'b0, 8'h00);
    checkOutput(K_IFG, 12, 32'h08);
    waitCycles(5);
    applyStimulus(8'h85, 1'b0, 1'b0, 8'h00);
    waitCycles(10);

    for (int k = 0; k < 100 && sb.size() != 0; k++) waitCycles(1);
    if (sb.size() != 0) begin
      $display("[TB] FAIL drain pending=%0d got=%0d want=0", sb.size(), sb.size());
      total += sb.size();
      bad   += sb.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
